// File: rtl/onewire_xfer_engine.sv
// rtl/onewire_xfer_engine.sv - 1-Wire bus reset/presence, word write and word read engine
// Each timed phase reloads a down-counter with its length minus one and exits when the counter reaches zero.
module onewire_xfer_engine #(
  parameter int CLKS_PER_US = 50,
  parameter int NBITS       = 8,
  parameter int T_RSTL      = 480,
  parameter int T_PDWAIT    = 70,
  parameter int T_RSTREC    = 410,
  parameter int T_RDL       = 6,
  parameter int T_RDS       = 9,
  parameter int T_RDREC     = 55,
  parameter int T_W1L       = 6,
  parameter int T_W1REC     = 64,
  parameter int T_W0L       = 60,
  parameter int T_W0REC     = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [NBITS-1:0] wdata,
  input  logic             dq_in,
  output logic             dq_out_en,
  output logic [NBITS-1:0] rdata,
  output logic             presence,
  output logic             busy,
  output logic             done
);

  function automatic int umax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAXT = umax(umax(umax(T_RSTL, T_PDWAIT), umax(T_RSTREC, T_RDL)),
                        umax(umax(umax(T_RDS, T_RDREC), umax(T_W1L, T_W1REC)), umax(T_W0L, T_W0REC)))
                        * CLKS_PER_US;
  localparam int CW = $clog2(MAXT + 1);
  localparam int IW = (NBITS > 1) ? $clog2(NBITS) : 1;

  localparam logic [CW-1:0] L_RSTL   = CW'(T_RSTL * CLKS_PER_US - 1);
  localparam logic [CW-1:0] L_PDWAIT = CW'(T_PDWAIT * CLKS_PER_US - 1);
  localparam logic [CW-1:0] L_RSTREC = CW'(T_RSTREC * CLKS_PER_US - 1);
  localparam logic [CW-1:0] L_RDL    = CW'(T_RDL * CLKS_PER_US - 1);
  localparam logic [CW-1:0] L_RDS    = CW'(T_RDS * CLKS_PER_US - 1);
  localparam logic [CW-1:0] L_RDREC  = CW'(T_RDREC * CLKS_PER_US - 1);
  localparam logic [CW-1:0] L_W1L    = CW'(T_W1L * CLKS_PER_US - 1);
  localparam logic [CW-1:0] L_W1REC  = CW'(T_W1REC * CLKS_PER_US - 1);
  localparam logic [CW-1:0] L_W0L    = CW'(T_W0L * CLKS_PER_US - 1);
  localparam logic [CW-1:0] L_W0REC  = CW'(T_W0REC * CLKS_PER_US - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NBITS - 1);

  localparam logic [1:0] OP_RST = 2'b00;
  localparam logic [1:0] OP_WR  = 2'b01;
  localparam logic [1:0] OP_RD  = 2'b10;
  localparam logic [1:0] OP_BAD = 2'b11;

  typedef enum logic [2:0] {
    IDLE, RST_LOW, RST_WAIT, RST_REC, SLOT_LOW, SLOT_SAMPLE, SLOT_REC, FINISH
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IW-1:0]    idx_q, idx_d, idx_nxt;
  logic [1:0]       op_q, op_d;
  logic [NBITS-1:0] wdata_q, wdata_d;
  logic [NBITS-1:0] rdata_q, rdata_d;
  logic             presence_q, presence_d;
  logic             last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      op_q       <= OP_RST;
      wdata_q    <= '0;
      rdata_q    <= '0;
      presence_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      op_q       <= op_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      presence_q <= presence_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    op_d       = op_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    presence_d = presence_q;
    idx_nxt    = idx_q + 1'b1;
    last       = (cnt_q == '0);
    if (!last) cnt_d = cnt_q - 1'b1;

    case (state_q)
      IDLE: begin
        if (start && op != OP_BAD) begin
          op_d    = op;
          wdata_d = wdata;
          idx_d   = '0;
          if (op == OP_RST) begin
            state_d = RST_LOW;
            cnt_d   = L_RSTL;
          end else begin
            state_d = SLOT_LOW;
            cnt_d   = (op == OP_RD) ? L_RDL : (wdata[0] ? L_W1L : L_W0L);
          end
        end
      end
      RST_LOW: if (last) begin
        state_d = RST_WAIT;
        cnt_d   = L_PDWAIT;
      end
      RST_WAIT: if (last) begin
        presence_d = ~dq_in;
        state_d    = RST_REC;
        cnt_d      = L_RSTREC;
      end
      RST_REC: if (last) state_d = FINISH;
      SLOT_LOW: if (last) begin
        if (op_q == OP_RD) begin
          state_d = SLOT_SAMPLE;
          cnt_d   = L_RDS;
        end else begin
          state_d = SLOT_REC;
          cnt_d   = wdata_q[idx_q] ? L_W1REC : L_W0REC;
        end
      end
      SLOT_SAMPLE: if (last) begin
        rdata_d[idx_q] = dq_in;
        state_d        = SLOT_REC;
        cnt_d          = L_RDREC;
      end
      SLOT_REC: if (last) begin
        idx_d = idx_nxt;
        if (idx_q == LAST_IDX) begin
          state_d = FINISH;
        end else begin
          state_d = SLOT_LOW;
          cnt_d   = (op_q == OP_RD) ? L_RDL : (wdata_q[idx_nxt] ? L_W1L : L_W0L);
        end
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode the state register directly so an async reset releases the bus at once.
  assign dq_out_en = (state_q == RST_LOW) || (state_q == SLOT_LOW);
  assign busy      = (state_q != IDLE) && (state_q != FINISH);
  assign done      = (state_q == FINISH);
  assign rdata     = rdata_q;
  assign presence  = presence_q;

endmodule
